// File: rtl/eee_vip_pkg.sv
// Shared constants and types for the video bounding-box blocks.
package eee_vip_pkg;
  localparam int COORD_W = 11;

  localparam logic [1:0] MODE_PASS   = 2'd0;
  localparam logic [1:0] MODE_HILITE = 2'd1;
  localparam logic [1:0] MODE_BOX    = 2'd2;
  localparam logic [1:0] MODE_BOTH   = 2'd3;

  localparam logic [1:0] FLD_LO  = 2'd0;
  localparam logic [1:0] FLD_HI  = 2'd1;
  localparam logic [1:0] FLD_MIN = 2'd2;
  localparam logic [1:0] FLD_MAX = 2'd3;

  localparam logic [3:0] PKT_VIDEO = 4'h0;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic   valid;
    coord_t ymin;
    coord_t xmin;
    coord_t ymax;
    coord_t xmax;
  } box_t;

  function automatic logic [31:0] pack_corner(input logic v, input coord_t y, input coord_t x);
    return {v, 4'b0, y, 5'b0, x};
  endfunction
endpackage

// File: rtl/eee_bbox_track.sv
// One colour channel: threshold registers, live box tracker and latched result box.
module eee_bbox_track
  import eee_vip_pkg::*;
#(
  parameter int BPS     = 8,
  parameter int IMAGE_W = 640,
  parameter int IMAGE_H = 480
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             pix_en,
  input  logic             latch,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [3*BPS-1:0] wdata,
  input  logic [3*BPS-1:0] pix,
  input  coord_t           x,
  input  coord_t           y,
  output logic             match,
  output logic             on_perim,
  output logic [3*BPS-1:0] lo,
  output logic [3*BPS-1:0] hi,
  output box_t             res
);
  localparam box_t LIVE_INIT = '{valid: 1'b0,
                                 ymin: COORD_W'(IMAGE_H-1), xmin: COORD_W'(IMAGE_W-1),
                                 ymax: '0, xmax: '0};

  box_t live, live_nxt;
  logic in_x, in_y;

  always_comb begin
    match = 1'b1;
    for (int s = 0; s < 3; s++)
      if (pix[s*BPS +: BPS] < lo[s*BPS +: BPS] || pix[s*BPS +: BPS] > hi[s*BPS +: BPS])
        match = 1'b0;
  end

  always_comb begin
    live_nxt = live;
    if (match) begin
      live_nxt.valid = 1'b1;
      if (x < live.xmin) live_nxt.xmin = x;
      if (y < live.ymin) live_nxt.ymin = y;
      if (x > live.xmax) live_nxt.xmax = x;
      if (y > live.ymax) live_nxt.ymax = y;
    end
  end

  // Perimeter test runs against the previous frame's latched box.
  assign in_x     = (x >= res.xmin) && (x <= res.xmax);
  assign in_y     = (y >= res.ymin) && (y <= res.ymax);
  assign on_perim = res.valid && ((in_y && (x == res.xmin || x == res.xmax)) ||
                                  (in_x && (y == res.ymin || y == res.ymax)));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lo   <= '0;
      hi   <= '1;
      live <= LIVE_INIT;
      res  <= '0;
    end else begin
      if (wr_lo) lo <= wdata;
      if (wr_hi) hi <= wdata;
      if (clr) live <= LIVE_INIT;
      else if (pix_en) begin
        live <= latch ? LIVE_INIT : live_nxt;
        if (latch) res <= live_nxt;
      end
    end
  end
endmodule

// File: rtl/eee_multi_bbox.sv
// Multi-colour bounding-box finder on an Avalon-ST video stream with MM register access.
module eee_multi_bbox
  import eee_vip_pkg::*;
#(
  parameter int NUM_COLOURS = 4,
  parameter int IMAGE_W     = 640,
  parameter int IMAGE_H     = 480,
  parameter int BPS         = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3*BPS-1:0] sink_data,
  input  logic             sink_valid,
  output logic             sink_ready,
  input  logic             sink_sop,
  input  logic             sink_eop,
  output logic [3*BPS-1:0] source_data,
  output logic             source_valid,
  input  logic             source_ready,
  output logic             source_sop,
  output logic             source_eop,
  input  logic [4:0]       s_address,
  input  logic             s_read,
  input  logic             s_write,
  input  logic [31:0]      s_writedata,
  output logic [31:0]      s_readdata,
  input  logic [1:0]       mode,
  output logic             frame_done
);
  localparam int     PW    = 3*BPS;
  localparam coord_t XLAST = COORD_W'(IMAGE_W-1);
  localparam coord_t YLAST = COORD_W'(IMAGE_H-1);

  logic accept, hdr, pix_en, vid_hdr, in_video, hl_en, box_en;
  logic [1:0] mode_q;
  coord_t x, y;
  logic [2:0] col;
  logic [1:0] fld;
  logic [PW-1:0] out_pix;
  logic [31:0] rd_mux;
  logic [NUM_COLOURS-1:0] match_v, perim_v;
  logic [NUM_COLOURS-1:0][PW-1:0] lo_a, hi_a;
  box_t [NUM_COLOURS-1:0] res_a;
  logic unused_wdata;

  assign unused_wdata = ^s_writedata;
  assign sink_ready = source_ready || !source_valid;
  assign accept     = sink_valid && sink_ready;
  assign hdr        = accept && sink_sop;
  assign vid_hdr    = hdr && (sink_data[3:0] == PKT_VIDEO);
  assign pix_en     = accept && !sink_sop && in_video;
  assign hl_en      = (mode_q == MODE_HILITE) || (mode_q == MODE_BOTH);
  assign box_en     = (mode_q == MODE_BOX) || (mode_q == MODE_BOTH);
  assign col        = s_address[4:2];
  assign fld        = s_address[1:0];

  for (genvar c = 0; c < NUM_COLOURS; c++) begin : g_trk
    eee_bbox_track #(.BPS(BPS), .IMAGE_W(IMAGE_W), .IMAGE_H(IMAGE_H)) u_trk (
      .clk      (clk),
      .reset_n  (reset_n),
      .clr      (vid_hdr),
      .pix_en   (pix_en),
      .latch    (sink_eop),
      .wr_lo    (s_write && col == 3'(c) && fld == FLD_LO),
      .wr_hi    (s_write && col == 3'(c) && fld == FLD_HI),
      .wdata    (s_writedata[PW-1:0]),
      .pix      (sink_data),
      .x        (x),
      .y        (y),
      .match    (match_v[c]),
      .on_perim (perim_v[c]),
      .lo       (lo_a[c]),
      .hi       (hi_a[c]),
      .res      (res_a[c])
    );
  end

  // Box drawing wins over highlight on the same pixel.
  always_comb begin
    out_pix = sink_data;
    if (pix_en) begin
      if (box_en && |perim_v)     out_pix = ~sink_data;
      else if (hl_en && |match_v) out_pix = '1;
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NUM_COLOURS; c++)
      if (col == 3'(c))
        case (fld)
          FLD_LO:  rd_mux = 32'(lo_a[c]);
          FLD_HI:  rd_mux = 32'(hi_a[c]);
          FLD_MIN: rd_mux = pack_corner(res_a[c].valid, res_a[c].ymin, res_a[c].xmin);
          default: rd_mux = pack_corner(res_a[c].valid, res_a[c].ymax, res_a[c].xmax);
        endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      source_data  <= '0;
      source_valid <= 1'b0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
      frame_done   <= 1'b0;
      s_readdata   <= '0;
      x            <= '0;
      y            <= '0;
      in_video     <= 1'b0;
      mode_q       <= MODE_PASS;
    end else begin
      frame_done <= pix_en && sink_eop;
      if (s_read) s_readdata <= rd_mux;
      if (accept) begin
        source_data  <= out_pix;
        source_valid <= 1'b1;
        source_sop   <= sink_sop;
        source_eop   <= sink_eop;
      end else if (source_ready) begin
        source_valid <= 1'b0;
      end
      if (hdr) begin
        in_video <= vid_hdr;
        x        <= '0;
        y        <= '0;
        if (vid_hdr) mode_q <= mode;
      end else if (pix_en) begin
        if (sink_eop) in_video <= 1'b0;
        if (x == XLAST) begin
          x <= '0;
          if (y != YLAST) y <= y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_eee_multi_bbox.sv
// Scoreboard bench for eee_multi_bbox on a 4x2 image.
module tb_eee_multi_bbox;
  localparam logic [23:0] RED = 24'hFF0000;
  localparam logic [23:0] GRY = 24'h101010;

  logic        clk, reset_n;
  logic [23:0] sink_data, source_data;
  logic        sink_valid, sink_ready, sink_sop, sink_eop;
  logic        source_valid, source_ready, source_sop, source_eop;
  logic [4:0]  s_address;
  logic        s_read, s_write;
  logic [31:0] s_writedata, s_readdata;
  logic [1:0]  mode;
  logic        frame_done;

  int n_checks = 0, n_fail = 0, n_pop = 0, fd_cnt = 0;
  logic bp_en = 1'b0;
  logic [25:0] exp_q[$];
  logic [25:0] mon_e;
  logic [23:0] fr_pix[16], fr_exp[16];
  logic [31:0] rd;

  eee_multi_bbox #(.NUM_COLOURS(4), .IMAGE_W(4), .IMAGE_H(2), .BPS(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .sink_data(sink_data), .sink_valid(sink_valid), .sink_ready(sink_ready),
    .sink_sop(sink_sop), .sink_eop(sink_eop),
    .source_data(source_data), .source_valid(source_valid), .source_ready(source_ready),
    .source_sop(source_sop), .source_eop(source_eop),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_readdata(s_readdata),
    .mode(mode), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  always @(negedge clk) source_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  always @(negedge clk) if (frame_done) fd_cnt++;

  // Output monitor: a transfer completes at the next posedge when valid&ready now.
  always @(negedge clk) begin
    #2;
    if (reset_n && source_valid && source_ready) begin
      n_checks++;
      n_pop++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL stream_extra got %h sop %b eop %b want nothing", source_data, source_sop, source_eop);
      end else begin
        mon_e = exp_q.pop_front();
        if ({source_data, source_sop, source_eop} !== mon_e) begin
          n_fail++;
          $display("FAIL stream_beat got %h/%b/%b want %h/%b/%b", source_data, source_sop, source_eop,
                   mon_e[25:2], mon_e[1], mon_e[0]);
        end
      end
    end
  end

  task automatic send_beat(input logic [23:0] d, input logic sop, input logic eop, input logic [23:0] e);
    int t = 0;
    @(negedge clk);
    sink_data = d; sink_sop = sop; sink_eop = eop; sink_valid = 1'b1;
    #1;
    while (!sink_ready) begin
      @(negedge clk); #1;
      t++;
      if (t > 1000) begin
        n_checks++; n_fail++;
        $display("FAIL accept_timeout got ready %b want 1", sink_ready);
        break;
      end
    end
    exp_q.push_back({e, sop, eop});
    @(posedge clk); #1;
    sink_valid = 1'b0;
  endtask

  task automatic fill_frame();
    for (int i = 0; i < 16; i++) begin fr_pix[i] = GRY; fr_exp[i] = GRY; end
  endtask

  task automatic send_frame(input int n);
    send_beat(24'h0, 1'b1, 1'b0, 24'h0);
    for (int i = 0; i < n; i++) send_beat(fr_pix[i], 1'b0, i == n-1, fr_exp[i]);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
  endtask

  task automatic mm_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk); s_address = a; s_writedata = d; s_write = 1'b1;
    @(negedge clk); s_write = 1'b0;
  endtask

  task automatic mm_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk); s_address = a; s_read = 1'b1;
    @(negedge clk); s_read = 1'b0; d = s_readdata;
  endtask

  task automatic set_thresholds();
    mm_write(5'd0, 32'h800000);
    mm_write(5'd1, 32'hFF3F3F);
    for (int c = 1; c < 4; c++) begin
      mm_write(5'(c*4), 32'hFFFFFF);
      mm_write(5'(c*4+1), 32'h000000);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (source_valid !== 1'b0) begin n_fail++; $display("FAIL rst_source_valid got %b want 0", source_valid); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done got %b want 0", frame_done); end
    n_checks++; if (sink_ready !== 1'b1) begin n_fail++; $display("FAIL rst_sink_ready got %b want 1", sink_ready); end
    n_checks++; if (s_readdata !== 32'h0) begin n_fail++; $display("FAIL rst_readdata got %h want 0", s_readdata); end
    mm_read(5'd0, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rst_lo got %h want 0", rd); end
    mm_read(5'd9, rd);
    n_checks++; if (rd !== 32'h00FFFFFF) begin n_fail++; $display("FAIL rst_hi got %h want 00ffffff", rd); end
    mm_read(5'd2, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rst_box got %h want 0", rd); end
    mm_write(5'd20, 32'h00000ABC);
    mm_read(5'd20, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL bad_colour_read got %h want 0", rd); end
  endtask

  task automatic test_bbox();
    set_thresholds();
    mode = 2'd0;
    fill_frame();
    fr_pix[1] = RED; fr_exp[1] = RED;
    fr_pix[6] = RED; fr_exp[6] = RED;
    fd_cnt = 0;
    send_frame(8);
    drain();
    n_checks++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL bbox_frame_done got %0d want 1", fd_cnt); end
    mm_read(5'd2, rd);
    n_checks++; if (rd !== 32'h80000001) begin n_fail++; $display("FAIL bbox_min got %h want 80000001", rd); end
    mm_read(5'd3, rd);
    n_checks++; if (rd !== 32'h80010002) begin n_fail++; $display("FAIL bbox_max got %h want 80010002", rd); end
    mm_read(5'd6, rd);
    n_checks++; if (rd[31] !== 1'b0) begin n_fail++; $display("FAIL bbox_c1_valid got %b want 0", rd[31]); end
  endtask

  task automatic test_ctrl_packet();
    fd_cnt = 0;
    send_beat(24'h00000F, 1'b1, 1'b0, 24'h00000F);
    send_beat(24'h123456, 1'b0, 1'b0, 24'h123456);
    send_beat(24'hABCDEF, 1'b0, 1'b1, 24'hABCDEF);
    drain();
    n_checks++; if (fd_cnt !== 0) begin n_fail++; $display("FAIL ctrl_frame_done got %0d want 0", fd_cnt); end
    mm_read(5'd2, rd);
    n_checks++; if (rd !== 32'h80000001) begin n_fail++; $display("FAIL ctrl_box_kept got %h want 80000001", rd); end
  endtask

  task automatic test_mode_box();
    fill_frame();
    fr_pix[1] = RED; fr_pix[6] = RED;
    for (int i = 0; i < 8; i++) fr_exp[i] = (i % 4 == 1 || i % 4 == 2) ? ~fr_pix[i] : fr_pix[i];
    mode = 2'd2;
    send_beat(24'h0, 1'b1, 1'b0, 24'h0);
    mode = 2'd0;
    for (int i = 0; i < 8; i++) send_beat(fr_pix[i], 1'b0, i == 7, fr_exp[i]);
    drain();
    mm_read(5'd3, rd);
    n_checks++; if (rd !== 32'h80010002) begin n_fail++; $display("FAIL box_mode_result got %h want 80010002", rd); end
  endtask

  task automatic test_mode_both();
    fill_frame();
    fr_pix[0] = RED; fr_exp[0] = 24'hFFFFFF;
    fr_pix[1] = RED; fr_exp[1] = 24'h00FFFF;
    fr_exp[2] = 24'hEFEFEF; fr_exp[5] = 24'hEFEFEF; fr_exp[6] = 24'hEFEFEF;
    mode = 2'd3;
    send_frame(8);
    mode = 2'd0;
    drain();
    mm_read(5'd3, rd);
    n_checks++; if (rd !== 32'h80000001) begin n_fail++; $display("FAIL both_mode_result got %h want 80000001", rd); end
  endtask

  task automatic test_boundaries();
    fill_frame();
    fr_pix[4] = RED; fr_exp[4] = RED;
    fd_cnt = 0;
    send_frame(5);
    drain();
    n_checks++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL early_eop_frame_done got %0d want 1", fd_cnt); end
    mm_read(5'd2, rd);
    n_checks++; if (rd !== 32'h80010000) begin n_fail++; $display("FAIL early_eop_min got %h want 80010000", rd); end
    fill_frame();
    fr_pix[0] = RED; fr_exp[0] = RED;
    fr_pix[9] = RED; fr_exp[9] = RED;
    send_frame(12);
    drain();
    mm_read(5'd2, rd);
    n_checks++; if (rd !== 32'h80000000) begin n_fail++; $display("FAIL long_frame_min got %h want 80000000", rd); end
    mm_read(5'd3, rd);
    n_checks++; if (rd !== 32'h80010001) begin n_fail++; $display("FAIL long_frame_ysat got %h want 80010001", rd); end
  endtask

  task automatic test_no_match();
    fill_frame();
    fd_cnt = 0;
    send_frame(8);
    drain();
    n_checks++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL nomatch_frame_done got %0d want 1", fd_cnt); end
    mm_read(5'd2, rd);
    n_checks++; if (rd[31] !== 1'b0) begin n_fail++; $display("FAIL nomatch_valid got %b want 0", rd[31]); end
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = n_pop;
    bp_en = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 8; i++) begin
        fr_pix[i] = 24'($urandom);
        fr_exp[i] = fr_pix[i];
      end
      send_beat(24'h0, 1'b1, 1'b0, 24'h0);
      for (int i = 0; i < 8; i++) begin
        repeat ($urandom_range(0, 1)) @(negedge clk);
        send_beat(fr_pix[i], 1'b0, i == 7, fr_exp[i]);
      end
    end
    drain();
    bp_en = 1'b0;
    drain();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_leftover got %0d want 0", exp_q.size()); end
    n_checks++; if (n_pop - p0 != 27) begin n_fail++; $display("FAIL bp_beat_count got %0d want 27", n_pop - p0); end
  endtask

  task automatic test_reset_mid();
    send_beat(24'h0, 1'b1, 1'b0, 24'h0);
    for (int i = 0; i < 3; i++) send_beat(24'h202020, 1'b0, 1'b0, 24'h202020);
    @(negedge clk); #3;
    reset_n = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (source_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_source_valid got %b want 0", source_valid); end
    @(negedge clk);
    reset_n = 1'b1;
    mm_read(5'd0, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL midrst_lo got %h want 0", rd); end
    mm_read(5'd1, rd);
    n_checks++; if (rd !== 32'h00FFFFFF) begin n_fail++; $display("FAIL midrst_hi got %h want 00ffffff", rd); end
    mm_read(5'd2, rd);
    n_checks++; if (rd[31] !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b want 0", rd[31]); end
    fd_cnt = 0;
    send_beat(24'h202020, 1'b0, 1'b0, 24'h202020);
    send_beat(24'h202020, 1'b0, 1'b1, 24'h202020);
    drain();
    n_checks++; if (fd_cnt !== 0) begin n_fail++; $display("FAIL midrst_tail_done got %0d want 0", fd_cnt); end
    set_thresholds();
    fill_frame();
    fr_pix[3] = RED; fr_exp[3] = RED;
    fr_pix[4] = RED; fr_exp[4] = RED;
    send_frame(8);
    drain();
    n_checks++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL midrst_frame_done got %0d want 1", fd_cnt); end
    mm_read(5'd2, rd);
    n_checks++; if (rd !== 32'h80000000) begin n_fail++; $display("FAIL midrst_min got %h want 80000000", rd); end
    mm_read(5'd3, rd);
    n_checks++; if (rd !== 32'h80010003) begin n_fail++; $display("FAIL midrst_max got %h want 80010003", rd); end
  endtask

  initial begin
    reset_n = 1'b0; sink_data = '0; sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    s_address = '0; s_read = 1'b0; s_write = 1'b0; s_writedata = '0; mode = 2'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_bbox();
    test_ctrl_packet();
    test_mode_box();
    test_mode_both();
    test_boundaries();
    test_no_match();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
